muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit for the multicycle RISC-V core, sitting beside the ALU in the execute stage. It generalises ALU operation decoding to the M-extension `funct3` space and is parameterised in `XLEN`. It runs a start/busy/done handshake with the control FSM, which stalls while `busy` is high. It produces RISC-V-exact results for all eight M operations, including divide-by-zero and signed overflow.

---
 rtl/muldiv_unit_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative M-extension multiply/divide unit:
// funct3 operation codes, FSM state encoding and the default operand width.
package muldiv_unit_pkg;

  localparam int unsigned MD_XLEN_DEFAULT = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_MD_IDLE = 2'd0,
    ST_MD_CALC = 2'd1,
    ST_MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_mul(input logic [2:0] f);
    return !f[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply (hi/lo shift right),
// restoring trial-subtract for divide (hi = partial remainder, lo = quotient).
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN_DEFAULT
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    // remainder shifted left can exceed XLEN bits, hence the extra bit
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = (shifted >= {1'b0, b_i});
    diff    = shifted - {1'b0, b_i};
    if (is_div_i) begin
      hi_o = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with start/busy/done handshake.
// Optional MULDIV_FAST_SPECIAL_EN: finish trivial cases (x/0, overflow, zero mul) at accept.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN_DEFAULT
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic            neg_q, neg_d, done_q, done_d;

  logic [XLEN-1:0]   hi_step, lo_step;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              acc_neg;
  logic [2*XLEN-1:0] prod_abs, prod_fix;
  logic [XLEN-1:0]   fix_res;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (hi_step),
    .lo_o     (lo_step)
  );

  always_comb begin : accept_decode
    a_neg = rs1[XLEN-1] && (funct3 inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM});
    b_neg = rs2[XLEN-1] && (funct3 inside {FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM});
    abs_a = a_neg ? -rs1 : rs1;
    abs_b = b_neg ? -rs2 : rs2;
    if (md_is_mul(funct3))
      acc_neg = a_neg ^ b_neg;
    else if (!funct3[1])
      acc_neg = (a_neg ^ b_neg) && (rs2 != '0);
    else
      acc_neg = a_neg;
  end

  always_comb begin : fast_path
    fast_hit = 1'b0;
    fast_res = '0;
`ifdef MULDIV_FAST_SPECIAL_EN
    if (funct3[2]) begin
      if (rs2 == '0) begin
        fast_hit = 1'b1;
        fast_res = funct3[1] ? rs1 : '1;
      end else if (!funct3[0] && rs1 == MOST_NEG && rs2 == '1) begin
        fast_hit = 1'b1;
        fast_res = funct3[1] ? '0 : MOST_NEG;
      end
    end else if (rs1 == '0 || rs2 == '0) begin
      fast_hit = 1'b1;
    end
`endif
  end

  always_comb begin : fix_select
    prod_abs = {hi_q, lo_q};
    prod_fix = neg_q ? -prod_abs : prod_abs;
    case (op_q)
      FUNCT3_MUL:                           fix_res = prod_fix[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU,
      FUNCT3_MULHU:                         fix_res = prod_fix[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:              fix_res = neg_q ? -lo_q : lo_q;
      default:                              fix_res = neg_q ? -hi_q : hi_q;
    endcase
  end

  always_comb begin : next_state
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_MD_IDLE: begin
        if (start && !flush) begin
          op_d  = funct3;
          neg_d = acc_neg;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = md_is_mul(funct3) ? abs_b : abs_a;
          b_d   = md_is_mul(funct3) ? abs_a : abs_b;
          if (fast_hit) begin
            result_d = fast_res;
            done_d   = 1'b1;
          end else begin
            state_d = ST_MD_CALC;
          end
        end
      end
      ST_MD_CALC: begin
        if (flush) begin
          state_d = ST_MD_IDLE;
        end else begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1))
            state_d = ST_MD_FIX;
        end
      end
      ST_MD_FIX: begin
        state_d = ST_MD_IDLE;
        if (!flush) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_MD_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_MD_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_MD_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32), with or without
// MULDIV_FAST_SPECIAL_EN.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            iCLK = 1'b0;
  logic            iRST_N;
  logic            start, flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int unsigned total = 0;
  int unsigned bad   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves at the negedge of the done cycle so the next
  // call issues start inside that done cycle (back-to-back).
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit special);
    int unsigned lat, lat_exp;
    bit seen, busy_ok;
    lat_exp = (FAST && special) ? 1 : XLEN + 2;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge iCLK);
    #1 start = 1'b0;
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge iCLK);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(exp));
  endtask

  initial begin
    bit seen_done, busy_ok;
    iRST_N = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);

    do_op("mul",     FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mulh",    FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    do_op("mulhu",   FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu",  FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mulh_m1", FUNCT3_MULH,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0);
    do_op("div",     FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("rem",     FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("divu",    FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
    do_op("remu",    FUNCT3_REMU,   32'd100,        32'd7,         32'd2,         1'b0);
    do_op("div_n",   FUNCT3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_n",   FUNCT3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0);
    do_op("div0",    FUNCT3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
    do_op("remu0",   FUNCT3_REMU,   32'd5,          32'd0,         32'd5,         1'b1);
    do_op("rem0n",   FUNCT3_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1);
    do_op("div_ov",  FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_op("rem_ov",  FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1);
    do_op("mul0",    FUNCT3_MUL,    32'd0,          32'd123,       32'd0,         1'b1);
    do_op("divu_pre",FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);

    // Ignored start in cycle 5, flush in cycle 10; result stays 14.
    funct3 = FUNCT3_REMU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge iCLK);
    #1 start = 1'b0;
    seen_done = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge iCLK);
      if (done === 1'b1) seen_done = 1'b1;
      if (c >= 1 && c <= 10 && busy !== 1'b1) busy_ok = 1'b0;
      if (c == 11) chk("flush_busy_low", 64'(busy), 64'd0);
      if (c == 5) begin funct3 = FUNCT3_MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; end
      if (c == 6) start = 1'b0;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
    end
    chk("flush_busy_before", 64'(busy_ok), 64'd1);
    chk("flush_no_done", 64'(seen_done), 64'd0);
    chk("flush_keep_res", 64'(result), 64'd14);
    do_op("after_flush", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 1'b0);

    // Reset in cycle 12 of a divide.
    funct3 = FUNCT3_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; start = 1'b1;
    @(posedge iCLK);
    #1 start = 1'b0;
    repeat (12) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_result", 64'(result), 64'd0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge iCLK);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("mrst_no_activity", 64'(seen_done), 64'd0);
    chk("mrst_result_hold", 64'(result), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
